// File: rtl/countdown_timer_pkg.sv
// timer_pkg: types and BCD limits shared by the countdown timer block.
//   timer_state_t  : SET / RUN / PAUSE / ALARM controller states
//   BCD_MAX_SEC10  : largest tens digit of a minutes or seconds field
//   BCD_MAX_DIGIT  : largest BCD digit value
package timer_pkg;

  typedef enum logic [1:0] {SET, RUN, PAUSE, ALARM} timer_state_t;

  localparam logic [3:0] BCD_MAX_SEC10 = 4'd5;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: button pulses in, display value and status flags out.
//   btn_start/btn_min/btn_sec/btn_clear : 1-cycle pulses from the debounce chain
//   value                               : packed BCD {min10,min1,sec10,sec1}
//   running/alarm/blank                 : status flags and display blank request
// master = button source / display consumer, slave = countdown_timer.
interface countdown_timer_if;
  logic        btn_start;
  logic        btn_min;
  logic        btn_sec;
  logic        btn_clear;
  logic [15:0] value;
  logic        running;
  logic        alarm;
  logic        blank;

  modport master (
    output btn_start, btn_min, btn_sec, btn_clear,
    input  value, running, alarm, blank
  );

  modport slave (
    input  btn_start, btn_min, btn_sec, btn_clear,
    output value, running, alarm, blank
  );
endinterface

// File: rtl/countdown_timer_tick_gen.sv
// tick_gen: 1 s prescaler, counts 0..CLK_HZ-1 and wraps.
//   clk, reset_p : clock, async active-high reset
//   i_run        : advance the count (otherwise hold)
//   i_clr        : force the count to 0 (wins over i_run)
//   o_tick       : 1-cycle pulse while running with the count at CLK_HZ-1
module tick_gen #(
  parameter int CLK_HZ = 125_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
    end
  end

  // Not gated by i_clr: the controller's own priority decides what a tick
  // does, and gating here would loop back through the clear decision.
  assign o_tick = i_run && (r_cnt == CNT_MAX);

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS countdown (00:00-59:59) with alarm and auto-rearm.
//   clk, reset_p : clock, async active-high reset
//   bus (slave)  : button pulses in; BCD value, running, alarm, blank out
// Parameters: CLK_HZ (clk cycles per 1 s tick), ALARM_SEC (alarm hold, 1..255).
// Build option TIMER_ALARM_BLINK_EN: blank toggles every CLK_HZ/4 cycles while
// in ALARM; without it blank is tied to 0.
//
// state | meaning
// SET   | value editable with min/sec, start arms if value != 00:00
// RUN   | decrement once per tick, reaching 00:00 enters ALARM
// PAUSE | value and prescaler frozen, start resumes
// ALARM | alarm flag up, returns to SET with the preset after ALARM_SEC ticks
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ    = 125_000_000,
  parameter int ALARM_SEC = 10
) (
  input  logic clk,
  input  logic reset_p,
  countdown_timer_if.slave bus
);

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_SEC - 1);

  timer_state_t r_state;
  logic [15:0]  r_value;
  logic [15:0]  r_preset;
  logic [7:0]   r_alarm_cnt;
  logic         r_running;
  logic         r_alarm;

  logic         w_tick;
  logic         w_presc_run;
  logic         w_presc_clr;
  logic         w_alarm_done;
  logic         w_leave_alarm;
  logic [15:0]  w_value_dec;

  // +1 on a two-digit BCD field with 59 -> 00 wrap, no carry out.
  function automatic logic [7:0] bcd_inc60(input logic [7:0] f);
    logic [7:0] res;
    res = f;
    if (f[3:0] >= BCD_MAX_DIGIT) begin
      res[3:0] = 4'd0;
      res[7:4] = (f[7:4] >= BCD_MAX_SEC10) ? 4'd0 : f[7:4] + 4'd1;
    end else begin
      res[3:0] = f[3:0] + 4'd1;
    end
    return res;
  endfunction

  // -1 on MM:SS with borrows; only used with a non-zero value.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] res;
    res = v;
    if (v[3:0] != 4'd0) begin
      res[3:0] = v[3:0] - 4'd1;
    end else begin
      res[3:0] = BCD_MAX_DIGIT;
      if (v[7:4] != 4'd0) begin
        res[7:4] = v[7:4] - 4'd1;
      end else begin
        res[7:4] = BCD_MAX_SEC10;
        if (v[11:8] != 4'd0) begin
          res[11:8] = v[11:8] - 4'd1;
        end else begin
          res[11:8]  = BCD_MAX_DIGIT;
          res[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return res;
  endfunction

  assign w_value_dec   = bcd_dec(r_value);
  assign w_presc_run   = (r_state == RUN) || (r_state == ALARM);
  assign w_alarm_done  = (r_state == ALARM) && w_tick && (r_alarm_cnt == ALARM_LAST);
  assign w_leave_alarm = (r_state == ALARM) && (bus.btn_clear || bus.btn_start || w_alarm_done);

  // Prescaler restarts on every state entry except RUN<->PAUSE, so a paused
  // count picks up exactly where it stopped. RUN->ALARM needs no explicit
  // clear: that transition only happens on a tick, where the count wraps.
  assign w_presc_clr = (r_state == SET) || bus.btn_clear || w_leave_alarm;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk     (clk),
    .reset_p (reset_p),
    .i_run   (w_presc_run),
    .i_clr   (w_presc_clr),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state     <= SET;
      r_value     <= 16'h0000;
      r_preset    <= 16'h0000;
      r_alarm_cnt <= 8'd0;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      case (r_state)
        SET: begin
          if (bus.btn_clear) begin
            r_value <= 16'h0000;
          end else if (bus.btn_start) begin
            if (r_value != 16'h0000) begin
              r_preset  <= r_value;
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end else if (bus.btn_min) begin
            r_value[15:8] <= bcd_inc60(r_value[15:8]);
          end else if (bus.btn_sec) begin
            r_value[7:0] <= bcd_inc60(r_value[7:0]);
          end
        end
        RUN: begin
          if (bus.btn_clear) begin
            r_state   <= SET;
            r_value   <= 16'h0000;
            r_running <= 1'b0;
          end else if (bus.btn_start) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else if (w_tick) begin
            r_value <= w_value_dec;
            if (w_value_dec == 16'h0000) begin
              r_state     <= ALARM;
              r_running   <= 1'b0;
              r_alarm     <= 1'b1;
              r_alarm_cnt <= 8'd0;
            end
          end
        end
        PAUSE: begin
          if (bus.btn_clear) begin
            r_state <= SET;
            r_value <= 16'h0000;
          end else if (bus.btn_start) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        ALARM: begin
          if (bus.btn_clear) begin
            r_state <= SET;
            r_value <= 16'h0000;
            r_alarm <= 1'b0;
          end else if (bus.btn_start || w_alarm_done) begin
            r_state <= SET;
            r_value <= r_preset;
            r_alarm <= 1'b0;
          end else if (w_tick) begin
            r_alarm_cnt <= r_alarm_cnt + 8'd1;
          end
        end
        default: begin
          r_state   <= SET;
          r_running <= 1'b0;
          r_alarm   <= 1'b0;
        end
      endcase
    end
  end

`ifdef TIMER_ALARM_BLINK_EN
  localparam int BLINK_DIV = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);

  logic [31:0] r_blink_cnt;
  logic        r_blank;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_blink_cnt <= 32'd0;
      r_blank     <= 1'b0;
    end else if ((r_state == ALARM) && !w_leave_alarm) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= 32'd0;
        r_blank     <= ~r_blank;
      end else begin
        r_blink_cnt <= r_blink_cnt + 32'd1;
      end
    end else begin
      r_blink_cnt <= 32'd0;
      r_blank     <= 1'b0;
    end
  end

  assign bus.blank = r_blank;
`else
  assign bus.blank = 1'b0;
`endif

  assign bus.value   = r_value;
  assign bus.running = r_running;
  assign bus.alarm   = r_alarm;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed bench for countdown_timer with CLK_HZ=10,
// ALARM_SEC=2. Buttons change on the falling edge, outputs are read there.
module tb_countdown_timer;

  localparam logic [3:0] B_CLR   = 4'b1000;
  localparam logic [3:0] B_START = 4'b0100;
  localparam logic [3:0] B_MIN   = 4'b0010;
  localparam logic [3:0] B_SEC   = 4'b0001;

  logic clk = 1'b0;
  logic reset_p;
  int   n_tests = 0;
  int   n_fail  = 0;

  countdown_timer_if bus();

  countdown_timer #(.CLK_HZ(10), .ALARM_SEC(2)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called on a falling edge: buttons are sampled by the next rising edge,
  // and the task returns on the falling edge right after it.
  task automatic press(input logic [3:0] b);
    {bus.btn_clear, bus.btn_start, bus.btn_min, bus.btn_sec} = b;
    @(negedge clk);
    {bus.btn_clear, bus.btn_start, bus.btn_min, bus.btn_sec} = 4'b0000;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic exp_blank;
    {bus.btn_clear, bus.btn_start, bus.btn_min, bus.btn_sec} = 4'b0000;

    // reset and start ignored at 00:00
    reset_p = 1'b1;
    #12;
    check_val("rst_value",   bus.value,   16'h0000);
    check_val("rst_running", 16'(bus.running), 16'd0);
    check_val("rst_alarm",   16'(bus.alarm),   16'd0);
    check_val("rst_blank",   16'(bus.blank),   16'd0);
    @(negedge clk);
    reset_p = 1'b0;
    press(B_START);
    check_val("start_zero_value",   bus.value, 16'h0000);
    check_val("start_zero_running", 16'(bus.running), 16'd0);
    wait_clk(12);
    check_val("start_zero_hold", bus.value, 16'h0000);

    // setting
    repeat (61) press(B_SEC);
    check_val("sec_wrap", bus.value, 16'h0001);
    repeat (3) press(B_MIN);
    check_val("min_inc", bus.value, 16'h0301);
    press(B_CLR);
    check_val("set_clear", bus.value, 16'h0000);
    repeat (59) press(B_MIN);
    press(B_MIN);
    check_val("min_wrap", bus.value, 16'h0000);
    press(B_MIN | B_SEC);
    check_val("prio_min_over_sec", bus.value, 16'h0100);
    press(B_CLR | B_START | B_MIN);
    check_val("prio_clear_value",   bus.value, 16'h0000);
    check_val("prio_clear_running", 16'(bus.running), 16'd0);

    // countdown into alarm
    repeat (2) press(B_SEC);
    press(B_START);
    check_val("run_running", 16'(bus.running), 16'd1);
    wait_clk(9);
    check_val("run_before_tick", bus.value, 16'h0002);
    wait_clk(1);
    check_val("run_tick1", bus.value, 16'h0001);
    wait_clk(10);
    check_val("run_zero_value",   bus.value, 16'h0000);
    check_val("run_zero_alarm",   16'(bus.alarm),   16'd1);
    check_val("run_zero_running", 16'(bus.running), 16'd0);
    check_val("alarm_blank0",     16'(bus.blank),   16'd0);

    // alarm timeout with blink pattern
    for (int k = 1; k < 20; k++) begin
      wait_clk(1);
      check_val("alarm_hold", 16'(bus.alarm), 16'd1);
`ifdef TIMER_ALARM_BLINK_EN
      exp_blank = ((k / 2) % 2) == 1;
`else
      exp_blank = 1'b0;
`endif
      check_val("alarm_blank", 16'(bus.blank), 16'(exp_blank));
    end
    wait_clk(1);
    check_val("alarm_timeout_alarm", 16'(bus.alarm), 16'd0);
    check_val("alarm_timeout_value", bus.value, 16'h0002);
    check_val("alarm_timeout_blank", 16'(bus.blank), 16'd0);

    // pause with prescaler at 4
    press(B_START);
    wait_clk(4);
    press(B_START);
    check_val("pause_running", 16'(bus.running), 16'd0);
    wait_clk(50);
    check_val("pause_hold", bus.value, 16'h0002);
    press(B_START);
    check_val("resume_running", 16'(bus.running), 16'd1);
    wait_clk(4);
    check_val("resume_before", bus.value, 16'h0002);
    wait_clk(1);
    check_val("resume_tick", bus.value, 16'h0001);
    press(B_CLR);
    check_val("run_clear_value",   bus.value, 16'h0000);
    check_val("run_clear_running", 16'(bus.running), 16'd0);

    // borrow chains
    repeat (10) press(B_MIN);
    check_val("set_1000", bus.value, 16'h1000);
    press(B_START);
    wait_clk(10);
    check_val("borrow_1000", bus.value, 16'h0959);
    press(B_CLR);
    press(B_MIN);
    press(B_START);
    wait_clk(10);
    check_val("borrow_0100", bus.value, 16'h0059);
    press(B_CLR);

    // clear during alarm
    press(B_SEC);
    press(B_START);
    wait_clk(10);
    check_val("alarm2_alarm", 16'(bus.alarm), 16'd1);
    press(B_CLR);
    check_val("alarm_clear_value", bus.value, 16'h0000);
    check_val("alarm_clear_alarm", 16'(bus.alarm), 16'd0);
    press(B_START);
    check_val("alarm_clear_is_set", 16'(bus.running), 16'd0);

    // start acknowledges alarm and rearms
    press(B_SEC);
    press(B_START);
    wait_clk(10);
    check_val("alarm3_alarm", 16'(bus.alarm), 16'd1);
    press(B_START);
    check_val("alarm_ack_value", bus.value, 16'h0001);
    check_val("alarm_ack_alarm", 16'(bus.alarm), 16'd0);

    // start coinciding with the 00:01 tick pauses instead of alarming
    press(B_START);
    wait_clk(9);
    press(B_START);
    check_val("start_tick_value",   bus.value, 16'h0001);
    check_val("start_tick_alarm",   16'(bus.alarm),   16'd0);
    check_val("start_tick_running", 16'(bus.running), 16'd0);
    press(B_CLR);

    // asynchronous reset mid-count
    repeat (5) press(B_SEC);
    press(B_START);
    wait_clk(3);
    #2 reset_p = 1'b1;
    #1;
    check_val("async_rst_value",   bus.value, 16'h0000);
    check_val("async_rst_running", 16'(bus.running), 16'd0);
    @(negedge clk);
    reset_p = 1'b0;
    wait_clk(12);
    check_val("after_rst_idle", bus.value, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
